hydra_port_scheduler: RTL and testbench
=======================================

// Module: hydra_port_scheduler
// PURPOSE
// - Per-output-port read scheduler for the hydra switch. Picks one of NUM_PRI priority queues (strict or WRR) and reads one whole packet.
// - Sequences the word pops from packet memory and frames the packet on rd_sop/rd_vld/rd_eop; the data path is outside this block.
// - One instance per output port; wrr_en is that port's bit of the top-level wrr_enable.
// PARAMETERS
// - NUM_PRI   8   priority queues per port; index 7 is highest.
// - LEN_W     9   width of the packet-length field in the header (words).
// - WEIGHT_W  4   width of the per-priority WRR quantum, counted in packets.
// PORTS
// - clk           in   1                  clock; all state on posedge
// - rst           in   1                  asynchronous, active-high reset
// - wrr_en        in   1                  1 = weighted round robin; 0 = strict priority
// - ready         in   1                  one-cycle request for one packet from the consumer
// - q_nonempty    in   NUM_PRI            queue i holds at least one complete packet
// - q_head_len    in   NUM_PRI*LEN_W      head-packet length of queue i; valid while q_nonempty[i]
// - q_weight      in   NUM_PRI*WEIGHT_W   WRR quantum of queue i
// - pop_req       out  1                  pop one word from queue pop_pri
// - pop_pri       out  3                  queue being popped
// - pop_last      out  1                  marks the final pop of the packet
// - rd_sop        out  1                  packet start; one cycle before the first rd_vld
// - rd_vld        out  1                  word valid; pop_req delayed 1 cycle (memory latency)
// - rd_eop        out  1                  packet end; one cycle after the last rd_vld
// - busy          out  1                  high in every state other than IDLE
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE; pending=0; credits=0; rr pointer=NUM_PRI-1.
// - Reset mid-packet aborts at once: no further pop_req, rd_vld or rd_eop.
// - ready sets a single-deep pending flag. Pulses while pending is already set are absorbed.
// - FSM state IDLE:
//   - Go to ARB when pending && |q_nonempty.
//   - Otherwise stay in IDLE; pending is held.
// - FSM state ARB (1 cycle):
//   - Choose the granted queue g; latch L = q_head_len[g], with 0 treated as 1.
//   - Clear pending; go to XFER.
// - FSM state XFER (L cycles):
//   - pop_req=1 and pop_pri=g every cycle.
//   - rd_sop=1 on the first XFER cycle only.
//   - pop_last=1 on the L-th cycle; 9-bit down-counter, no wrap.
// - FSM states DRAIN, then EOP, then back to IDLE.
// - Latency from the edge that samples ready, on an idle FSM with a nonempty queue:
//   - rd_sop at +3; rd_vld from +4 to +3+L; rd_eop at +4+L.
// - Strict mode (wrr_en=0): g is the highest-index nonempty queue. Credits are not touched.
// - WRR mode (wrr_en=1):
//   - Each queue has a WEIGHT_W credit counter; a weight of 0 is treated as 1.
//   - g is the first nonempty queue with credit>0, scanning downward from the rr pointer with wrap-around.
//   - At grant: credit[g] decrements by 1; the rr pointer moves to g-1 once credit[g] reaches 0.
//   - If no nonempty queue has credit, all credits reload from q_weight in ARB, then selection proceeds in the same cycle.
// - wrr_en is sampled in ARB only; a change during a packet applies from the next packet.
// - q_nonempty[g] must stay high until pop_last. The block does not check it.
// CONFIGURATION
// - Macro HYDRA_SCHED_STATS_EN:
//   - Defined: adds output stat_pkt_cnt [NUM_PRI*16], one saturating 16-bit counter per queue, incremented at EOP and cleared by rst.
//   - Undefined: the port and the counters are absent. Behaviour is otherwise identical.
// STRUCTURE
// - hydra_pkg holds: NUM_PORT=16, NUM_PRI, LEN_W, the header field typedef {len[8:0], pri[2:0], dst[3:0]}, and the sched_state_e enum {IDLE, ARB, XFER, DRAIN, EOP}.
// - One sub-module, hydra_wrr_arbiter: the credit counters, rr pointer and grant logic.
// TESTING
// - Strict, single packet: q_nonempty=8'h10, len[4]=34, ready pulse at T -> rd_sop@T+3, 34 rd_vld T+4..T+37, rd_eop@T+38, pop_pri=4.
// - Strict priority: queues 2 and 3 nonempty, two ready pulses -> queue 3 is served first, then queue 2; wrr_en=0.
// - WRR: weights q7=2, q3=1, both always nonempty, 6 packets -> grant order 7,7,3,7,7,3.
// - Length edges: L=1 -> one rd_vld with pop_last on it; L=0 -> handled as 1; L=511 -> exactly 511 rd_vld.
// - Pending: ready while busy -> next packet's ARB follows EOP->IDLE immediately; ready with all queues empty -> IDLE held, served once a queue fills.
// - rst asserted mid-XFER -> outputs 0 in the same cycle (async); credits cleared; next packet served normally.

Source files
------------

// File: rtl/hydra_port_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// hydra_pkg
// Purpose : shared constants, header layout and scheduler state encoding for
//           the hydra switch output-port scheduler.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package hydra_pkg;

  localparam int NUM_PORT = 16;  // output ports on the switch
  localparam int NUM_PRI  = 8;   // priority queues per port, index 7 highest
  localparam int LEN_W    = 9;   // packet length field, in words
  localparam int WEIGHT_W = 4;   // WRR quantum, in packets
  localparam int PRI_W    = 3;   // log2(NUM_PRI)
  localparam int DST_W    = 4;   // log2(NUM_PORT)
  localparam int STAT_W   = 16;  // per-queue packet counter width

  // Packet header as stored at the head of each queue.
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [PRI_W-1:0] pri;
    logic [DST_W-1:0] dst;
  } hydra_hdr_t;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    XFER,
    DRAIN,
    EOP
  } sched_state_e;

  // A zero-length header still occupies one word in packet memory.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/hydra_port_scheduler_if.sv
// -----------------------------------------------------------------------------
// hydra_port_scheduler_if
// Purpose : bundles the queue-status inputs and the pop/framing outputs of one
//           output-port scheduler.
// Signals : wrr_en, ready, q_nonempty, q_head_len, q_weight   (to scheduler)
//           pop_req, pop_pri, pop_last, rd_sop, rd_vld,
//           rd_eop, busy                                     (from scheduler)
// Modports: master = queue manager / consumer side, slave = scheduler.
// -----------------------------------------------------------------------------
interface hydra_port_scheduler_if;

  logic                                              wrr_en;
  logic                                              ready;
  logic [hydra_pkg::NUM_PRI-1:0]                     q_nonempty;
  logic [hydra_pkg::NUM_PRI*hydra_pkg::LEN_W-1:0]    q_head_len;
  logic [hydra_pkg::NUM_PRI*hydra_pkg::WEIGHT_W-1:0] q_weight;

  logic                                              pop_req;
  logic [hydra_pkg::PRI_W-1:0]                       pop_pri;
  logic                                              pop_last;
  logic                                              rd_sop;
  logic                                              rd_vld;
  logic                                              rd_eop;
  logic                                              busy;

  modport master (
    output wrr_en, ready, q_nonempty, q_head_len, q_weight,
    input  pop_req, pop_pri, pop_last, rd_sop, rd_vld, rd_eop, busy
  );

  modport slave (
    input  wrr_en, ready, q_nonempty, q_head_len, q_weight,
    output pop_req, pop_pri, pop_last, rd_sop, rd_vld, rd_eop, busy
  );

endinterface

// File: rtl/hydra_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// hydra_wrr_arbiter
// Purpose : grant logic for one output port. Strict priority picks the highest
//           nonempty queue; WRR scans downward from a round-robin pointer for a
//           nonempty queue with credit, reloading all credits when none has any.
// Ports   : clk, rst          clock, async active-high reset
//           arb_en_i          scheduler is in ARB; commits credit/pointer update
//           wrr_en_i          1 = WRR, 0 = strict priority
//           q_nonempty_i      per-queue "has a packet"
//           q_weight_i        per-queue WRR quantum (0 behaves as 1)
//           gnt_o             granted queue index (combinational)
// -----------------------------------------------------------------------------
module hydra_wrr_arbiter
  import hydra_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_en_i,
  input  logic                        wrr_en_i,
  input  logic [NUM_PRI-1:0]          q_nonempty_i,
  input  logic [NUM_PRI*WEIGHT_W-1:0] q_weight_i,
  output logic [PRI_W-1:0]            gnt_o
);

  logic [WEIGHT_W-1:0] credit_q    [NUM_PRI];
  logic [WEIGHT_W-1:0] credit_base [NUM_PRI];
  logic [NUM_PRI-1:0]  has_credit;
  logic [NUM_PRI-1:0]  eligible;
  logic                reload;
  logic                update;
  logic [PRI_W-1:0]    ptr_q, ptr_d;
  logic [PRI_W-1:0]    strict_gnt;
  logic [PRI_W-1:0]    wrr_gnt;

  // When no nonempty queue has credit, selection works on freshly reloaded
  // credits in the same cycle, so every nonempty queue becomes eligible.
  assign reload   = ~|has_credit;
  assign eligible = reload ? q_nonempty_i : has_credit;
  assign update   = arb_en_i & wrr_en_i & (|q_nonempty_i);

  generate
    for (genvar gi = 0; gi < NUM_PRI; gi++) begin : g_q
      logic [WEIGHT_W-1:0] weight;
      logic [WEIGHT_W-1:0] cr_q, cr_d;

      assign weight         = q_weight_i[gi*WEIGHT_W +: WEIGHT_W];
      assign has_credit[gi] = q_nonempty_i[gi] & (cr_q != '0);
      assign credit_base[gi] = reload ? ((weight == '0) ? WEIGHT_W'(1) : weight) : cr_q;
      assign cr_d = !update                 ? cr_q :
                    (wrr_gnt == PRI_W'(gi)) ? credit_base[gi] - 1'b1 :
                                              credit_base[gi];
      assign credit_q[gi] = cr_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cr_q <= '0;
        else     cr_q <= cr_d;
      end
    end
  endgenerate

  // NUM_PRI is a power of two, so index arithmetic wraps naturally in PRI_W bits.
  always_comb begin
    logic [PRI_W-1:0] idx;
    logic             found;
    strict_gnt = '0;
    for (int i = 0; i < NUM_PRI; i++) begin
      if (q_nonempty_i[i]) strict_gnt = PRI_W'(i);
    end
    wrr_gnt = ptr_q;
    found   = 1'b0;
    idx     = ptr_q;
    for (int k = 0; k < NUM_PRI; k++) begin
      idx = ptr_q - PRI_W'(k);
      if (!found && eligible[idx]) begin
        wrr_gnt = idx;
        found   = 1'b1;
      end
    end
  end

  // The pointer only leaves a queue once its quantum is used up.
  assign ptr_d = (update && credit_base[wrr_gnt] == WEIGHT_W'(1)) ? wrr_gnt - PRI_W'(1) : ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= PRI_W'(NUM_PRI - 1);
    else     ptr_q <= ptr_d;
  end

  assign gnt_o = wrr_en_i ? wrr_gnt : strict_gnt;

endmodule

// File: rtl/hydra_port_scheduler.sv
// -----------------------------------------------------------------------------
// hydra_port_scheduler
// Purpose : per-output-port read scheduler. On a pending request it picks one
//           priority queue (strict or WRR), pops the whole head packet word by
//           word and frames it with rd_sop / rd_vld / rd_eop.
// Ports   : clk, rst       clock, async active-high reset
//           sif (slave)    queue status in; pop_req/pop_pri/pop_last,
//                          rd_sop/rd_vld/rd_eop, busy out
//           stat_pkt_cnt   only with HYDRA_SCHED_STATS_EN: saturating 16-bit
//                          packet counter per queue, bumped at EOP
// Config  : define HYDRA_SCHED_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module hydra_port_scheduler
  import hydra_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  hydra_port_scheduler_if.slave        sif
`ifdef HYDRA_SCHED_STATS_EN
  ,
  output logic [NUM_PRI*STAT_W-1:0]    stat_pkt_cnt
`endif
);

  sched_state_e     state_q, state_d;
  logic             pending_q, pending_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [PRI_W-1:0] pri_q, pri_d;
  logic [PRI_W-1:0] gnt;
  logic             first_q;
  logic             rd_vld_q;
  logic             any_ne;
  logic [LEN_W-1:0] head_len [NUM_PRI];

  generate
    for (genvar gi = 0; gi < NUM_PRI; gi++) begin : g_len
      assign head_len[gi] = sif.q_head_len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  assign any_ne = |sif.q_nonempty;

  hydra_wrr_arbiter u_arb (
    .clk          (clk),
    .rst          (rst),
    .arb_en_i     (state_q == ARB),
    .wrr_en_i     (sif.wrr_en),
    .q_nonempty_i (sif.q_nonempty),
    .q_weight_i   (sif.q_weight),
    .gnt_o        (gnt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers. rd_vld is pop_req delayed by the memory read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      cnt_q     <= '0;
      pri_q     <= '0;
      first_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      pri_q     <= pri_d;
      first_q   <= (state_q == ARB);
      rd_vld_q  <= (state_q == XFER);
    end
  end

  // Next state. A ready arriving during ARB is kept for the following packet.
  always_comb begin
    state_d   = state_q;
    pending_d = sif.ready | (pending_q & (state_q != ARB));
    cnt_d     = cnt_q;
    pri_d     = pri_q;
    case (state_q)
      IDLE:  if (pending_q && any_ne) state_d = ARB;
      ARB: begin
        state_d = XFER;
        pri_d   = gnt;
        cnt_d   = eff_len(head_len[gnt]);
      end
      XFER: begin
        if (cnt_q <= LEN_W'(1)) state_d = DRAIN;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      DRAIN: state_d = EOP;
      EOP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    sif.pop_req  = 1'b0;
    sif.pop_pri  = '0;
    sif.pop_last = 1'b0;
    sif.rd_sop   = 1'b0;
    sif.rd_eop   = 1'b0;
    case (state_q)
      XFER: begin
        sif.pop_req  = 1'b1;
        sif.pop_pri  = pri_q;
        sif.pop_last = (cnt_q <= LEN_W'(1));
        sif.rd_sop   = first_q;
      end
      EOP:     sif.rd_eop = 1'b1;
      default: ;
    endcase
    sif.rd_vld = rd_vld_q;
    sif.busy   = (state_q != IDLE);
  end

`ifdef HYDRA_SCHED_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_PRI; gi++) begin : g_stat
      logic [STAT_W-1:0] stat_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          stat_q <= '0;
        else if (state_q == EOP && pri_q == PRI_W'(gi) && stat_q != '1)
          stat_q <= stat_q + 1'b1;
      end
      assign stat_pkt_cnt[gi*STAT_W +: STAT_W] = stat_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_hydra_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hydra_port_scheduler
// Purpose : directed self-checking bench for hydra_port_scheduler (default
//           build). Each packet observed prints one line; cycle numbers are
//           counted from the edge that samples the stimulus (n = 1 is the
//           next edge).
// -----------------------------------------------------------------------------
module tb_hydra_port_scheduler;
  import hydra_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hydra_port_scheduler_if sif ();

  hydra_port_scheduler dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int sop_at [8];
  int vld_first [8];
  int vld_last [8];
  int vld_cnt [8];
  int eop_at [8];
  int last_at [8];
  int last_cnt [8];
  int pkt_pri [8];
  int pri_bad [8];

  task automatic set_len(input int q, input logic [LEN_W-1:0] v);
    sif.q_head_len[q*LEN_W +: LEN_W] = v;
  endtask

  task automatic set_weight(input int q, input logic [WEIGHT_W-1:0] v);
    sif.q_weight[q*WEIGHT_W +: WEIGHT_W] = v;
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 sif.ready = 1'b1;
    @(posedge clk); #1 sif.ready = 1'b0;
  endtask

  // Records framing events for up to npk packets, sampling mid-cycle.
  task automatic observe(input int npk, input int budget);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      sop_at[i] = -1; vld_first[i] = -1; vld_last[i] = -1; vld_cnt[i] = 0;
      eop_at[i] = -1; last_at[i] = -1; last_cnt[i] = 0; pkt_pri[i] = -1; pri_bad[i] = 0;
    end
    for (int n = 1; n <= budget && p < npk; n++) begin
      @(negedge clk);
      if (sif.rd_sop) begin
        sop_at[p]  = n;
        pkt_pri[p] = int'(sif.pop_pri);
      end
      if (sif.pop_req) begin
        if (int'(sif.pop_pri) != pkt_pri[p]) pri_bad[p]++;
        if (sif.pop_last) begin
          last_at[p] = n;
          last_cnt[p]++;
        end
      end
      if (sif.rd_vld) begin
        if (vld_cnt[p] == 0) vld_first[p] = n;
        vld_last[p] = n;
        vld_cnt[p]++;
      end
      if (sif.rd_eop) begin
        eop_at[p] = n;
        $display("pkt pri=%0d sop@%0d vld=%0d (%0d..%0d) last@%0d eop@%0d",
                 pkt_pri[p], sop_at[p], vld_cnt[p], vld_first[p], vld_last[p], last_at[p], n);
        p++;
      end
    end
  endtask

  function automatic logic [9:0] out_vec();
    return {sif.busy, sif.pop_req, sif.pop_last, sif.rd_sop, sif.rd_vld, sif.rd_eop, 1'b0, sif.pop_pri};
  endfunction

  task automatic test_reset();
    logic [9:0] v;
    repeat (2) @(posedge clk);
    #1 v = out_vec();
    n_checks++; if (v !== 10'b0) begin n_fail++; $display("FAIL reset_outputs got %b want %b", v, 10'b0); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 v = out_vec();
    n_checks++; if (v !== 10'b0) begin n_fail++; $display("FAIL idle_outputs got %b want %b", v, 10'b0); end
  endtask

  task automatic test_strict_single();
    sif.wrr_en = 1'b0;
    sif.q_nonempty = 8'h10;
    set_len(4, 9'd34);
    pulse_ready();
    observe(1, 80);
    n_checks++; if (sop_at[0] !== 3)    begin n_fail++; $display("FAIL single_sop got %0d want 3", sop_at[0]); end
    n_checks++; if (vld_first[0] !== 4) begin n_fail++; $display("FAIL single_vld_first got %0d want 4", vld_first[0]); end
    n_checks++; if (vld_last[0] !== 37) begin n_fail++; $display("FAIL single_vld_last got %0d want 37", vld_last[0]); end
    n_checks++; if (vld_cnt[0] !== 34)  begin n_fail++; $display("FAIL single_vld_cnt got %0d want 34", vld_cnt[0]); end
    n_checks++; if (eop_at[0] !== 38)   begin n_fail++; $display("FAIL single_eop got %0d want 38", eop_at[0]); end
    n_checks++; if (pkt_pri[0] !== 4)   begin n_fail++; $display("FAIL single_pri got %0d want 4", pkt_pri[0]); end
    n_checks++; if (pri_bad[0] !== 0)   begin n_fail++; $display("FAIL single_pri_stable got %0d want 0", pri_bad[0]); end
    n_checks++; if (last_at[0] !== 36 || last_cnt[0] !== 1)
      begin n_fail++; $display("FAIL single_pop_last got @%0d x%0d want @36 x1", last_at[0], last_cnt[0]); end
    sif.q_nonempty = 8'h00;
  endtask

  // Queues 2 and 3 nonempty; a second ready arrives mid-packet and queue 3
  // empties after its packet, so queue 2 follows right after IDLE->ARB.
  task automatic test_back_to_back();
    sif.wrr_en = 1'b0;
    sif.q_nonempty = 8'h0C;
    set_len(2, 9'd4);
    set_len(3, 9'd4);
    pulse_ready();
    fork
      observe(2, 60);
      begin
        repeat (3) @(posedge clk);
        #1 sif.ready = 1'b1;
        @(posedge clk);
        #1 sif.ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (sif.rd_eop) break;
        end
        sif.q_nonempty = 8'h04;
      end
    join
    n_checks++; if (pkt_pri[0] !== 3) begin n_fail++; $display("FAIL b2b_first_pri got %0d want 3", pkt_pri[0]); end
    n_checks++; if (eop_at[0] !== 8)  begin n_fail++; $display("FAIL b2b_first_eop got %0d want 8", eop_at[0]); end
    n_checks++; if (pkt_pri[1] !== 2) begin n_fail++; $display("FAIL b2b_second_pri got %0d want 2", pkt_pri[1]); end
    n_checks++; if (sop_at[1] !== 11) begin n_fail++; $display("FAIL b2b_second_sop got %0d want 11", sop_at[1]); end
    n_checks++; if (vld_cnt[1] !== 4 || eop_at[1] !== 16)
      begin n_fail++; $display("FAIL b2b_second_frame got vld=%0d eop=%0d want vld=4 eop=16", vld_cnt[1], eop_at[1]); end
    sif.q_nonempty = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after got %b want 0", sif.busy); end
  endtask

  task automatic test_lengths();
    sif.wrr_en = 1'b0;
    sif.q_nonempty = 8'h01;
    set_len(0, 9'd1);
    pulse_ready();
    observe(1, 20);
    n_checks++; if (vld_cnt[0] !== 1 || vld_first[0] !== 4)
      begin n_fail++; $display("FAIL len1_vld got cnt=%0d first=%0d want cnt=1 first=4", vld_cnt[0], vld_first[0]); end
    n_checks++; if (last_at[0] !== 3 || last_cnt[0] !== 1)
      begin n_fail++; $display("FAIL len1_pop_last got @%0d x%0d want @3 x1", last_at[0], last_cnt[0]); end
    n_checks++; if (eop_at[0] !== 5) begin n_fail++; $display("FAIL len1_eop got %0d want 5", eop_at[0]); end

    set_len(0, 9'd0);
    pulse_ready();
    observe(1, 20);
    n_checks++; if (vld_cnt[0] !== 1 || last_cnt[0] !== 1)
      begin n_fail++; $display("FAIL len0_words got vld=%0d last=%0d want 1 1", vld_cnt[0], last_cnt[0]); end
    n_checks++; if (eop_at[0] !== 5) begin n_fail++; $display("FAIL len0_eop got %0d want 5", eop_at[0]); end

    set_len(0, 9'd511);
    pulse_ready();
    observe(1, 600);
    n_checks++; if (vld_cnt[0] !== 511) begin n_fail++; $display("FAIL len511_vld_cnt got %0d want 511", vld_cnt[0]); end
    n_checks++; if (last_at[0] !== 513 || last_cnt[0] !== 1)
      begin n_fail++; $display("FAIL len511_pop_last got @%0d x%0d want @513 x1", last_at[0], last_cnt[0]); end
    n_checks++; if (eop_at[0] !== 515) begin n_fail++; $display("FAIL len511_eop got %0d want 515", eop_at[0]); end
    sif.q_nonempty = 8'h00;
  endtask

  task automatic test_pending_empty();
    int busy_cycles;
    sif.wrr_en = 1'b0;
    sif.q_nonempty = 8'h00;
    pulse_ready();
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sif.busy) busy_cycles++;
    end
    n_checks++; if (busy_cycles !== 0) begin n_fail++; $display("FAIL empty_hold got busy=%0d want 0", busy_cycles); end
    set_len(1, 9'd3);
    @(posedge clk);
    #1 sif.q_nonempty = 8'h02;
    observe(1, 20);
    n_checks++; if (pkt_pri[0] !== 1 || sop_at[0] !== 3)
      begin n_fail++; $display("FAIL empty_fill_sop got pri=%0d sop=%0d want pri=1 sop=3", pkt_pri[0], sop_at[0]); end
    n_checks++; if (vld_cnt[0] !== 3 || eop_at[0] !== 7)
      begin n_fail++; $display("FAIL empty_fill_frame got vld=%0d eop=%0d want vld=3 eop=7", vld_cnt[0], eop_at[0]); end
    sif.q_nonempty = 8'h00;
  endtask

  task automatic test_wrr();
    int exp_order [6];
    exp_order = '{7, 7, 3, 7, 7, 3};
    sif.wrr_en = 1'b1;
    sif.q_weight = '0;
    set_weight(7, 4'd2);
    set_weight(3, 4'd1);
    set_len(7, 9'd2);
    set_len(3, 9'd2);
    sif.q_nonempty = 8'h88;
    for (int k = 0; k < 6; k++) begin
      pulse_ready();
      observe(1, 20);
      n_checks++; if (pkt_pri[0] !== exp_order[k])
        begin n_fail++; $display("FAIL wrr_grant_%0d got %0d want %0d", k, pkt_pri[0], exp_order[k]); end
    end
  endtask

  // WRR state on entry: credits 0, pointer 2. First packet reloads and takes
  // queue 7; the second drains 7's credit and moves the pointer to 6. A reset
  // mid-XFER must clear credits and pointer so queue 7 wins again afterwards.
  task automatic test_reset_mid_xfer();
    logic [9:0] v;
    int stray;
    sif.wrr_en = 1'b1;
    sif.q_nonempty = 8'h88;
    set_len(7, 9'd20);
    set_len(3, 9'd20);
    pulse_ready();
    observe(1, 40);
    n_checks++; if (pkt_pri[0] !== 7) begin n_fail++; $display("FAIL rstx_pre_pri got %0d want 7", pkt_pri[0]); end
    pulse_ready();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sif.pop_req) break;
    end
    @(negedge clk);
    n_checks++; if (sif.pop_req !== 1'b1) begin n_fail++; $display("FAIL rstx_in_xfer got %b want 1", sif.pop_req); end
    #1 rst = 1'b1;
    #1 v = out_vec();
    n_checks++; if (v !== 10'b0) begin n_fail++; $display("FAIL rstx_async_outputs got %b want %b", v, 10'b0); end
    @(posedge clk);
    #2 rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sif.pop_req || sif.rd_vld || sif.rd_eop || sif.busy) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rstx_no_activity got %0d want 0", stray); end
    pulse_ready();
    observe(1, 40);
    n_checks++; if (pkt_pri[0] !== 7) begin n_fail++; $display("FAIL rstx_post_pri got %0d want 7", pkt_pri[0]); end
    n_checks++; if (sop_at[0] !== 3 || vld_cnt[0] !== 20 || eop_at[0] !== 24)
      begin n_fail++; $display("FAIL rstx_post_frame got sop=%0d vld=%0d eop=%0d want 3 20 24", sop_at[0], vld_cnt[0], eop_at[0]); end
    sif.q_nonempty = 8'h00;
  endtask

  initial begin
    sif.wrr_en     = 1'b0;
    sif.ready      = 1'b0;
    sif.q_nonempty = '0;
    sif.q_head_len = '0;
    sif.q_weight   = '0;
    test_reset();
    test_strict_single();
    test_back_to_back();
    test_lengths();
    test_pending_empty();
    test_wrr();
    test_reset_mid_xfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
